// File: rtl/cp0_exception_ctrl.sv
// CP0 exception/interrupt sequencer: arbitrates exceptions, interrupts and ERET,
// drains the pipeline via flush_req/flush_ack, then commits EPC/Cause and redirects fetch.
module cp0_exception_ctrl #(
   parameter int unsigned NUM_HW_INT  = 6,
   parameter logic [31:0] VECTOR_ADDR = 32'h8000_0180
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           status,
   input  logic [NUM_HW_INT-1:0] hw_int,
   input  logic [3:0]            exc_req,
   input  logic [31:0]           exc_pc,
   input  logic                  eret_req,
   input  logic                  flush_ack,
   output logic                  flush_req,
   output logic                  activeexception,
   output logic                  eret,
   output logic                  pc_redirect,
   output logic [31:0]           redirect_pc,
   output logic [31:0]           epc,
   output logic [31:0]           cause,
   output logic                  busy
);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_EXC_FLUSH   = 3'd1,
      S_EXC_COMMIT  = 3'd2,
      S_ERET_FLUSH  = 3'd3,
      S_ERET_COMMIT = 3'd4
   } state_t;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_BP  = 5'd9;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;

   state_t      r_state;
   logic [4:0]  r_code;
   logic [31:0] r_pc;
   logic [31:0] r_epc;
   logic [31:0] r_cause;
   logic [31:0] r_redirect_pc;
   logic        r_flush_req;
   logic        r_activeexception;
   logic        r_eret;
   logic        r_pc_redirect;
   logic        r_busy;

   logic        w_int_pend;
   logic        w_take_exc;
   logic        w_take_eret;
   logic [4:0]  w_code;
   logic        w_unused;

   assign w_int_pend = status[0] & ~status[1] & (|(hw_int & status[10 +: NUM_HW_INT]));
   assign w_unused   = ^{status[31:16], status[9:2]};

   // Priority arbitration of pending events; illegal ERET (EXL clear) becomes RI.
   always_comb begin
      w_take_exc  = 1'b0;
      w_take_eret = 1'b0;
      w_code      = EXC_INT;
      if (exc_req[0]) begin
         w_take_exc = 1'b1;
         w_code     = EXC_RI;
      end else if (exc_req[1]) begin
         w_take_exc = 1'b1;
         w_code     = EXC_OV;
      end else if (exc_req[2]) begin
         w_take_exc = 1'b1;
         w_code     = EXC_SYS;
      end else if (exc_req[3]) begin
         w_take_exc = 1'b1;
         w_code     = EXC_BP;
      end else if (w_int_pend) begin
         w_take_exc = 1'b1;
         w_code     = EXC_INT;
      end else if (eret_req) begin
         if (status[1]) begin
            w_take_eret = 1'b1;
         end else begin
            w_take_exc = 1'b1;
            w_code     = EXC_RI;
         end
      end else begin
         w_take_exc  = 1'b0;
         w_take_eret = 1'b0;
      end
   end

   // Sequencer FSM with registered handshake, pulse and architectural-state outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state           <= S_IDLE;
         r_code            <= 5'd0;
         r_pc              <= 32'h0;
         r_epc             <= 32'h0;
         r_cause           <= 32'h0;
         r_redirect_pc     <= 32'h0;
         r_flush_req       <= 1'b0;
         r_activeexception <= 1'b0;
         r_eret            <= 1'b0;
         r_pc_redirect     <= 1'b0;
         r_busy            <= 1'b0;
      end else begin
         r_cause[10 +: NUM_HW_INT] <= hw_int;
         r_flush_req       <= 1'b0;
         r_activeexception <= 1'b0;
         r_eret            <= 1'b0;
         r_pc_redirect     <= 1'b0;
         r_redirect_pc     <= 32'h0;
         case (r_state)
            S_IDLE: begin
               if (w_take_exc) begin
                  r_code      <= w_code;
                  r_pc        <= exc_pc;
                  r_state     <= S_EXC_FLUSH;
                  r_flush_req <= 1'b1;
                  r_busy      <= 1'b1;
               end else if (w_take_eret) begin
                  r_state     <= S_ERET_FLUSH;
                  r_flush_req <= 1'b1;
                  r_busy      <= 1'b1;
               end else begin
                  r_busy      <= 1'b0;
               end
            end
            S_EXC_FLUSH: begin
               if (flush_ack) begin
                  r_state           <= S_EXC_COMMIT;
                  r_activeexception <= 1'b1;
                  r_pc_redirect     <= 1'b1;
                  r_redirect_pc     <= VECTOR_ADDR;
               end else begin
                  r_flush_req       <= 1'b1;
               end
            end
            S_EXC_COMMIT: begin
               r_epc        <= r_pc;
               r_cause[6:2] <= r_code;
               r_state      <= S_IDLE;
               r_busy       <= 1'b0;
            end
            S_ERET_FLUSH: begin
               if (flush_ack) begin
                  r_state       <= S_ERET_COMMIT;
                  r_eret        <= 1'b1;
                  r_pc_redirect <= 1'b1;
                  r_redirect_pc <= r_epc;
               end else begin
                  r_flush_req   <= 1'b1;
               end
            end
            S_ERET_COMMIT: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign flush_req       = r_flush_req;
   assign activeexception = r_activeexception;
   assign eret            = r_eret;
   assign pc_redirect     = r_pc_redirect;
   assign redirect_pc     = r_redirect_pc;
   assign epc             = r_epc;
   assign cause           = r_cause;
   assign busy            = r_busy;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed self-checking bench for cp0_exception_ctrl with hand-computed expectations.
module tb_cp0_exception_ctrl;

   logic        clk;
   logic        reset;
   logic [31:0] status;
   logic [5:0]  hw_int;
   logic [3:0]  exc_req;
   logic [31:0] exc_pc;
   logic        eret_req;
   logic        flush_ack;
   logic        flush_req;
   logic        activeexception;
   logic        eret;
   logic        pc_redirect;
   logic [31:0] redirect_pc;
   logic [31:0] epc;
   logic [31:0] cause;
   logic        busy;

   int n_checks;
   int n_errors;
   int n_pulses;

   cp0_exception_ctrl #(
      .NUM_HW_INT  (6),
      .VECTOR_ADDR (32'h8000_0180)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .status          (status),
      .hw_int          (hw_int),
      .exc_req         (exc_req),
      .exc_pc          (exc_pc),
      .eret_req        (eret_req),
      .flush_ack       (flush_ack),
      .flush_req       (flush_req),
      .activeexception (activeexception),
      .eret            (eret),
      .pc_redirect     (pc_redirect),
      .redirect_pc     (redirect_pc),
      .epc             (epc),
      .cause           (cause),
      .busy            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are settled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_val({tag, "_flush_req"}, {31'h0, flush_req}, 32'h0);
      check_val({tag, "_actexc"}, {31'h0, activeexception}, 32'h0);
      check_val({tag, "_eret"}, {31'h0, eret}, 32'h0);
      check_val({tag, "_redirect"}, {31'h0, pc_redirect}, 32'h0);
      check_val({tag, "_busy"}, {31'h0, busy}, 32'h0);
   endtask

   initial begin
      n_checks  = 0;
      n_errors  = 0;
      reset     = 1'b1;
      status    = 32'h0;
      hw_int    = 6'h0;
      exc_req   = 4'h0;
      exc_pc    = 32'h0;
      eret_req  = 1'b0;
      flush_ack = 1'b0;
      step();
      step();
      check_idle_outputs("rst");
      check_val("rst_epc", epc, 32'h0);
      check_val("rst_cause", cause, 32'h0);
      reset = 1'b0;

      // Syscall with flush_ack delayed three cycles
      exc_req = 4'b0100;
      exc_pc  = 32'h0040_0010;
      step();
      exc_req = 4'h0;
      for (int i = 0; i < 3; i++) begin
         check_val("sys_flush_req", {31'h0, flush_req}, 32'h1);
         check_val("sys_no_early_pulse", {31'h0, activeexception}, 32'h0);
         if (i == 2) flush_ack = 1'b1;
         step();
      end
      check_val("sys_flush_drop", {31'h0, flush_req}, 32'h0);
      check_val("sys_actexc", {31'h0, activeexception}, 32'h1);
      check_val("sys_redirect", {31'h0, pc_redirect}, 32'h1);
      check_val("sys_redirect_pc", redirect_pc, 32'h8000_0180);
      check_val("sys_no_eret", {31'h0, eret}, 32'h0);
      flush_ack = 1'b0;
      step();
      check_idle_outputs("sys_done");
      check_val("sys_epc", epc, 32'h0040_0010);
      check_val("sys_cause", cause, 32'h0000_0020);

      // Priority: Ov beats Bp, interrupt and ERET
      status    = 32'h0000_0402;
      hw_int    = 6'h01;
      exc_req   = 4'b1010;
      eret_req  = 1'b1;
      exc_pc    = 32'h0040_0100;
      flush_ack = 1'b1;
      step();
      exc_req  = 4'h0;
      eret_req = 1'b0;
      check_val("pri_flush_req", {31'h0, flush_req}, 32'h1);
      step();
      check_val("pri_actexc", {31'h0, activeexception}, 32'h1);
      check_val("pri_no_eret", {31'h0, eret}, 32'h0);
      step();
      check_val("pri_cause", cause, 32'h0000_0430);
      check_val("pri_epc", epc, 32'h0040_0100);
      flush_ack = 1'b0;
      hw_int    = 6'h00;

      // Interrupt masking
      hw_int = 6'h04;
      status = 32'h0000_0401;
      step();
      step();
      check_val("int_masked_busy", {31'h0, busy}, 32'h0);
      check_val("int_masked_flush", {31'h0, flush_req}, 32'h0);
      status = 32'h0000_1001;
      exc_pc = 32'h0040_0200;
      step();
      check_val("int_flush_req", {31'h0, flush_req}, 32'h1);
      flush_ack = 1'b1;
      step();
      check_val("int_actexc", {31'h0, activeexception}, 32'h1);
      flush_ack = 1'b0;
      step();
      check_val("int_cause", cause, 32'h0000_1000);
      check_val("int_epc", epc, 32'h0040_0200);
      status = 32'h0000_1003;
      step();
      step();
      check_val("int_exl_busy", {31'h0, busy}, 32'h0);
      check_val("int_exl_cause", cause, 32'h0000_1000);
      hw_int = 6'h00;

      // Re-enter via syscall to set EPC, then legal ERET
      status    = 32'h0000_0002;
      exc_req   = 4'b0100;
      exc_pc    = 32'h0040_0010;
      flush_ack = 1'b1;
      step();
      exc_req = 4'h0;
      step();
      step();
      check_val("pre_eret_epc", epc, 32'h0040_0010);
      eret_req = 1'b1;
      step();
      eret_req = 1'b0;
      check_val("eret_flush_req", {31'h0, flush_req}, 32'h1);
      check_val("eret_busy", {31'h0, busy}, 32'h1);
      step();
      check_val("eret_pulse", {31'h0, eret}, 32'h1);
      check_val("eret_no_actexc", {31'h0, activeexception}, 32'h0);
      check_val("eret_redirect", {31'h0, pc_redirect}, 32'h1);
      check_val("eret_redirect_pc", redirect_pc, 32'h0040_0010);
      check_val("eret_flush_drop", {31'h0, flush_req}, 32'h0);
      step();
      check_idle_outputs("eret_done");
      check_val("eret_epc_kept", epc, 32'h0040_0010);
      check_val("eret_cause_kept", cause, 32'h0000_0020);

      // Illegal ERET with EXL clear becomes RI
      status   = 32'h0;
      eret_req = 1'b1;
      exc_pc   = 32'h0040_0300;
      step();
      eret_req = 1'b0;
      check_val("ieret_flush_req", {31'h0, flush_req}, 32'h1);
      step();
      check_val("ieret_actexc", {31'h0, activeexception}, 32'h1);
      check_val("ieret_no_eret", {31'h0, eret}, 32'h0);
      step();
      check_val("ieret_cause", cause, 32'h0000_0028);
      check_val("ieret_epc", epc, 32'h0040_0300);

      // Requests arriving while busy are dropped
      flush_ack = 1'b0;
      exc_req   = 4'b0001;
      exc_pc    = 32'h0040_0400;
      step();
      exc_req = 4'h0;
      step();
      exc_req = 4'b0010;
      exc_pc  = 32'h0050_0000;
      step();
      exc_req   = 4'h0;
      flush_ack = 1'b1;
      n_pulses  = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (activeexception) n_pulses++;
      end
      check_val("busy_pulse_count", n_pulses, 32'd1);
      check_val("busy_cause", cause, 32'h0000_0028);
      check_val("busy_epc", epc, 32'h0040_0400);
      flush_ack = 1'b0;

      // Reset in the middle of an exception flush
      exc_req = 4'b0100;
      exc_pc  = 32'h0040_0500;
      step();
      exc_req = 4'h0;
      check_val("mid_flush_req", {31'h0, flush_req}, 32'h1);
      reset = 1'b1;
      step();
      check_idle_outputs("mid_rst");
      check_val("mid_rst_epc", epc, 32'h0);
      check_val("mid_rst_cause", cause, 32'h0);
      reset     = 1'b0;
      flush_ack = 1'b1;
      n_pulses  = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (activeexception || eret || pc_redirect || flush_req) n_pulses++;
      end
      check_val("post_rst_no_pulse", n_pulses, 32'd0);
      flush_ack = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
